grid_commit_scheduler: RTL
==========================

Name: grid_commit_scheduler

Overview:
- Sits between the Avalon-MM slave port and the 16x16-bit game grid register file that feeds the image mapper.
- Software writes land in a shadow grid and set per-row dirty bits.
- On the start of each vertical sync, or on a software-forced commit, an FSM copies dirty rows into the live grid one row per clock. The displayed frame never shows a half-updated board.

Parameters:
- ROWS, 16, number of grid rows; also the shadow and dirty-mask depth.
- ROW_W, 16, bits per grid row.
- SYNC_STAGES, 2, flip-flop stages on the vs input.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- AVL_READ  in  1  Avalon read strobe.
- AVL_WRITE  in  1  Avalon write strobe.
- AVL_CS  in  1  Avalon chip select; all accesses are qualified by AVL_CS.
- AVL_ADDR  in  5  word address.
- AVL_WRITEDATA  in  16  write data.
- AVL_READDATA  out  16  read data, registered.
- vs  in  1  VGA vertical sync, active low, asynchronous to CLK.
- grid_wr_en  out  1  one-cycle write strobe to the live grid.
- grid_wr_addr  out  4  live grid row index.
- grid_wr_data  out  16  row data.
- commit_busy  out  1  high while the FSM is in COMMIT.
- frame_toggle  out  1  flips once per completed commit.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET).
- Register map:
  - 0x00-0x0F: shadow rows, R/W.
  - 0x10: STATUS, RO. bit0 = commit_busy, bit1 = frame_toggle, bits15:2 = 0.
  - 0x11: CTRL, R/W.
    - bit0 = AUTO_EN, reset value 1.
    - bit1 = FORCE, write-1 pulse; always reads 0.
    - Other bits write-ignored and read 0.
  - 0x12: DIRTY mask, RO.
  - 0x13-0x1F: reads return 0; writes are ignored.
- Avalon write (AVL_WRITE & AVL_CS) to a row: shadow[addr] <= data and dirty[addr] <= 1 on the same edge.
- Avalon read: AVL_READDATA is valid the cycle after AVL_READ & AVL_CS (fixed read latency 1). It holds its value otherwise.
- vs path: passed through SYNC_STAGES flops to give vs_s. A falling edge of vs_s (1 in the previous cycle, 0 now) is a "vstart" event in that cycle.
- FSM states:
  - IDLE → COMMIT on the cycle after (vstart & AUTO_EN) or an accepted FORCE write. idx <= 0.
  - COMMIT: each cycle handles row idx.
    - If dirty[idx]: grid_wr_en = 1, grid_wr_addr = idx, grid_wr_data = shadow[idx], dirty[idx] cleared.
    - Otherwise grid_wr_en = 0.
    - idx increments each cycle.
    - After idx = ROWS-1, go to DONE.
  - DONE: one cycle. frame_toggle flips, then → IDLE.
- Timing: a commit occupies exactly ROWS+1 cycles after the trigger cycle. Row i is written on trigger+1+i.
- Write and commit on the same row in the same cycle:
  - Live grid receives the pre-write shadow value.
  - The new value is stored in the shadow.
  - dirty stays 1 (set wins over clear) and the row commits next frame.
- Write to a row with index > idx during COMMIT: the new value is committed in the same pass.
- Write to a row with index < idx: it stays dirty for the next commit.
- vstart or FORCE while in COMMIT or DONE: ignored, with no queuing.
- FORCE while AUTO_EN = 0: still triggers a commit.
- AUTO_EN = 0: vstart events are ignored.
- Clean rows are never written. A commit with dirty = 0 still runs all ROWS+1 cycles and toggles frame_toggle.
- Reset, including mid-commit:
  - FSM to IDLE; idx = 0.
  - Shadow rows = 0, dirty = 0, AUTO_EN = 1.
  - frame_toggle = 0, commit_busy = 0, grid_wr_en = 0, grid_wr_addr = 0, grid_wr_data = 0, AVL_READDATA = 0.
  - Synchronizer flops reset to 1 (vs idle level), so reset release does not produce a spurious vstart.
- Output timing: grid_wr_* are registered or driven from state regs only; they carry no combinational path from Avalon inputs.

Test Plan:
- Reset, then write 0xA5A5 to row 3 and 0x0001 to row 15, then drive vs 1→0. Required: DIRTY reads 0x8008 before the edge. After the edge, grid_wr_en pulses exactly twice: addr 3 with data 0xA5A5, then addr 15 with data 0x0001, 12 cycles apart. frame_toggle becomes 1 and DIRTY reads 0x0000.
- CTRL = 0 (AUTO_EN off), write row 0 = 0x1234, toggle vs three times. Required: no grid_wr_en. Then write CTRL = 0x2. Required: a single commit writes addr 0 with data 0x1234, and CTRL reads 0x0000.
- During a commit, write row 10 = 0xBEEF while idx = 4, and row 2 = 0xCAFE while idx = 6. Required: row 10 commits 0xBEEF in this pass. Row 2 is not written in this pass, DIRTY reads 0x0004 afterwards, and row 2 is committed on the next vstart.
- Same-cycle collision: write row 5 = 0x0F0F in the exact cycle the FSM commits row 5 (old shadow value 0x1111). Required: grid receives 0x1111, dirty[5] remains 1, and the next commit writes 0x0F0F.
- Assert RESET at idx = 7 of a commit. Required: all outputs go to 0 on the next cycle. STATUS and DIRTY read 0 and CTRL reads 0x0001. No vstart occurs after release while vs stays high.
- Read addresses 0x03, 0x10 and 0x1F. Required: data appears one cycle after the AVL_READ & AVL_CS strobe, and 0x1F returns 0x0000. A read with AVL_CS = 0 leaves AVL_READDATA unchanged.

Source files
------------

// File: rtl/grid_commit_scheduler.sv
// grid_commit_scheduler: Avalon-MM shadow grid with per-row dirty tracking.
// Dirty rows are copied into the live grid one row per clock. The copy starts
// at vertical sync start, or when software forces it, so a frame never shows
// a half-updated board.
//
// state  | meaning
// IDLE   | waiting for vstart (with AUTO_EN) or a FORCE write
// COMMIT | handling row idx this cycle; dirty rows are written to the live grid
// DONE   | one cycle; frame_toggle flips on exit
module grid_commit_scheduler #(
  parameter int ROWS        = 16,
  parameter int ROW_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    AVL_READ,
  input  logic                    AVL_WRITE,
  input  logic                    AVL_CS,
  input  logic [4:0]              AVL_ADDR,
  input  logic [ROW_W-1:0]        AVL_WRITEDATA,
  output logic [ROW_W-1:0]        AVL_READDATA,
  input  logic                    vs,
  output logic                    grid_wr_en,
  output logic [$clog2(ROWS)-1:0] grid_wr_addr,
  output logic [ROW_W-1:0]        grid_wr_data,
  output logic                    commit_busy,
  output logic                    frame_toggle
);

  localparam int IDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ROW_W-1:0]       shadow_q [ROWS];
  logic [ROWS-1:0]        dirty_q, dirty_d;
  logic                   auto_en_q;
  logic                   frame_toggle_q, frame_toggle_d;
  logic [ROW_W-1:0]       rd_data_q, rd_data_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vs_prev_q;

  logic                   vs_s;
  logic                   vstart;
  logic                   wr_acc;
  logic                   row_wr;
  logic                   ctrl_wr;
  logic                   force_req;
  logic                   commit_wr;
  logic [IDX_W-1:0]       wr_row;

  assign wr_acc    = AVL_WRITE & AVL_CS;
  assign row_wr    = wr_acc & ~AVL_ADDR[4];
  assign wr_row    = AVL_ADDR[IDX_W-1:0];
  assign ctrl_wr   = wr_acc & (AVL_ADDR == 5'h11);
  assign force_req = ctrl_wr & AVL_WRITEDATA[1];

  assign vs_s   = sync_q[SYNC_STAGES-1];
  assign vstart = vs_prev_q & ~vs_s;

  // Synchronize vs; flops idle high so reset release cannot fake a vstart.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q    <= '1;
      vs_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], vs};
      vs_prev_q <= vs_s;
    end
  end

  // FSM state, row index and frame toggle registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      frame_toggle_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      frame_toggle_q <= frame_toggle_d;
    end
  end

  // Next-state logic and the live-grid write decision for the current row.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    frame_toggle_d = frame_toggle_q;
    commit_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if ((vstart & auto_en_q) | force_req) state_d = COMMIT;
      end
      COMMIT: begin
        commit_wr = dirty_q[idx_q];
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(ROWS - 1)) state_d = DONE;
      end
      DONE: begin
        frame_toggle_d = ~frame_toggle_q;
        idx_d          = '0;
        state_d        = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Dirty mask: commit clears the row, and a software write in the same cycle wins.
  always_comb begin
    dirty_d = dirty_q;
    if (commit_wr) dirty_d[idx_q] = 1'b0;
    if (row_wr) dirty_d[wr_row] = 1'b1;
  end

  // Shadow rows, dirty mask and CTRL register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ROWS; i++) shadow_q[i] <= '0;
      dirty_q   <= '0;
      auto_en_q <= 1'b1;
    end else begin
      if (row_wr) shadow_q[wr_row] <= AVL_WRITEDATA;
      dirty_q <= dirty_d;
      if (ctrl_wr) auto_en_q <= AVL_WRITEDATA[0];
    end
  end

  // Read mux for the register map.
  always_comb begin
    rd_data_d = '0;
    if (!AVL_ADDR[4]) begin
      rd_data_d = shadow_q[AVL_ADDR[IDX_W-1:0]];
    end else begin
      case (AVL_ADDR)
        5'h10:   rd_data_d = {{(ROW_W-2){1'b0}}, frame_toggle_q, (state_q == COMMIT)};
        5'h11:   rd_data_d = {{(ROW_W-1){1'b0}}, auto_en_q};
        5'h12:   rd_data_d = ROW_W'(dirty_q);
        default: rd_data_d = '0;
      endcase
    end
  end

  // Read data register: fixed latency of one cycle, holds between reads.
  always_ff @(posedge CLK) begin
    if (RESET) rd_data_q <= '0;
    else if (AVL_READ & AVL_CS) rd_data_q <= rd_data_d;
  end

  // Live grid outputs come only from registered state, never from Avalon inputs.
  assign grid_wr_en   = commit_wr;
  assign grid_wr_addr = idx_q;
  assign grid_wr_data = commit_wr ? shadow_q[idx_q] : '0;
  assign commit_busy  = (state_q == COMMIT);
  assign frame_toggle = frame_toggle_q;
  assign AVL_READDATA = rd_data_q;

endmodule
